// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the NOP
// encoding, fetch FSM state encodings and the default reset PC.
package fetch_stage_pkg;

  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [DATA_W-1:0]  DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus and IF/ID pipeline-register bundle.
// master: the fetch stage; slave: instruction memory plus decode.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [DATA_W-1:0]  imem_addr_o;
  logic [INSTR_W-1:0] imem_instr_i;
  logic               ifid_valid_o;
  logic [DATA_W-1:0]  ifid_pc_o;
  logic [DATA_W-1:0]  ifid_pc4_o;
  logic [INSTR_W-1:0] ifid_instr_o;

  modport master (
    output imem_addr_o,
    input  imem_instr_i,
    output ifid_valid_o,
    output ifid_pc_o,
    output ifid_pc4_o,
    output ifid_instr_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_instr_i,
    input  ifid_valid_o,
    input  ifid_pc_o,
    input  ifid_pc4_o,
    input  ifid_instr_o
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC priority mux:
// not running / halt hold, then redirect load, then stall hold, else PC+4.
module fetch_pc_gen
  import fetch_stage_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              stall,
  output logic [DATA_W-1:0] pc
);

  logic [DATA_W-1:0] pc_next;

  // Select the next PC; PC+4 wraps modulo 2^DATA_W by construction.
  always_comb begin
    pc_next = pc;
    if (run && !halt) begin
      if (redirect)   pc_next = redirect_pc;
      else if (!stall) pc_next = pc + DATA_W'(4);
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: BOOT/RUN/HALTED FSM, PC generation and the
// IF/ID pipeline register. Optional feature macro: FETCH_MISALIGN_TRAP_EN
// (misaligned redirect sets a sticky flag and halts fetch instead of
// silently aligning the target).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [DATA_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic              halted_o,
  output logic              misaligned_o,
  fetch_stage_if.master     bus
);

  fetch_state_e       state_q, state_d;
  logic               run;
  logic               halt_eff;
  logic [DATA_W-1:0]  redirect_tgt;
  logic [DATA_W-1:0]  pc_p0;

  logic               ifid_valid_p1;
  logic [DATA_W-1:0]  ifid_pc_p1;
  logic [DATA_W-1:0]  ifid_pc4_p1;
  logic [INSTR_W-1:0] ifid_instr_p1;

  assign run = (state_q == ST_RUN);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_redirect;
  logic misaligned_q;

  // A misaligned redirect only counts when halt_i does not already win.
  assign mis_redirect = run && !halt_i && redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign halt_eff     = halt_i || mis_redirect;
  assign redirect_tgt = redirect_pc_i;

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            misaligned_q <= 1'b0;
    else if (mis_redirect) misaligned_q <= 1'b1;
  end

  assign misaligned_o = misaligned_q;
`else
  assign halt_eff     = halt_i;
  assign redirect_tgt = redirect_pc_i & ~DATA_W'(3);
  assign misaligned_o = 1'b0;
`endif

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .halt        (halt_eff),
    .redirect    (redirect_i),
    .redirect_pc (redirect_tgt),
    .stall       (stall_i),
    .pc          (pc_p0)
  );

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Next state: BOOT lasts one cycle, HALTED is absorbing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (halt_eff) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_BOOT;
    endcase
  end

  // ---- IF -> ID boundary: capture instruction at PC or insert a bubble ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_p1 <= 1'b0;
      ifid_pc_p1    <= '0;
      ifid_pc4_p1   <= '0;
      ifid_instr_p1 <= NOP_INSTR;
    end else if (run && !halt_eff && !redirect_i && stall_i) begin
      ifid_valid_p1 <= ifid_valid_p1;
    end else if (run && !halt_eff && !redirect_i && !flush_i) begin
      ifid_valid_p1 <= 1'b1;
      ifid_pc_p1    <= pc_p0;
      ifid_pc4_p1   <= pc_p0 + DATA_W'(4);
      ifid_instr_p1 <= bus.imem_instr_i;
    end else begin
      ifid_valid_p1 <= 1'b0;
      ifid_pc_p1    <= '0;
      ifid_pc4_p1   <= '0;
      ifid_instr_p1 <= NOP_INSTR;
    end
  end

  assign bus.imem_addr_o  = pc_p0;
  assign bus.ifid_valid_o = ifid_valid_p1;
  assign bus.ifid_pc_o    = ifid_pc_p1;
  assign bus.ifid_pc4_o   = ifid_pc4_p1;
  assign bus.ifid_instr_o = ifid_instr_p1;
  assign halted_o         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a 256-word combinational
// instruction memory whose word i holds 32'hA000_0000 + i.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              stall_i;
  logic              flush_i;
  logic              redirect_i;
  logic [DATA_W-1:0] redirect_pc_i;
  logic              halt_i;
  logic              halted_o;
  logic              misaligned_o;

  int n_tests;
  int n_fail;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (64'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .halted_o      (halted_o),
    .misaligned_o  (misaligned_o),
    .bus           (bus)
  );

  function automatic logic [31:0] mem_word(input int idx);
    return 32'hA000_0000 + 32'(idx);
  endfunction

  assign bus.imem_instr_i = 32'hA000_0000 + {24'h0, bus.imem_addr_o[9:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_valid(input string tag, input int idx, input logic [63:0] pc);
    check({tag, ".valid"}, 64'(bus.ifid_valid_o), 64'd1);
    check({tag, ".instr"}, 64'(bus.ifid_instr_o), 64'(mem_word(idx)));
    check({tag, ".pc"},    bus.ifid_pc_o, pc);
    check({tag, ".pc4"},   bus.ifid_pc4_o, pc + 64'd4);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, 64'(bus.ifid_valid_o), 64'd0);
    check({tag, ".instr"}, 64'(bus.ifid_instr_o), 64'h13);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; halt_i = 1'b0;
    repeat (2) step();

    // Reset state
    check_bubble("rst");
    check("rst.pc",     bus.ifid_pc_o, 64'h0);
    check("rst.pc4",    bus.ifid_pc4_o, 64'h0);
    check("rst.addr",   bus.imem_addr_o, 64'h0);
    check("rst.halted", 64'(halted_o), 64'd0);
    check("rst.mis",    64'(misaligned_o), 64'd0);

    rst_n = 1'b1;
    step();                         // BOOT edge
    check_bubble("boot");
    check("boot.addr", bus.imem_addr_o, 64'h0);
    step();
    check_valid("fetchA", 0, 64'h0);
    check("fetchA.addr", bus.imem_addr_o, 64'h4);
    step();
    check_valid("fetchB", 1, 64'h4);

    // Stall two cycles holds B
    stall_i = 1'b1;
    step(); check_valid("stall1", 1, 64'h4); check("stall1.addr", bus.imem_addr_o, 64'h8);
    step(); check_valid("stall2", 1, 64'h4); check("stall2.addr", bus.imem_addr_o, 64'h8);
    stall_i = 1'b0;
    step(); check_valid("fetchC", 2, 64'h8);

    // Redirect wins over stall
    redirect_i = 1'b1; redirect_pc_i = 64'h40; stall_i = 1'b1;
    step(); check_bubble("redir"); check("redir.addr", bus.imem_addr_o, 64'h40);
    redirect_i = 1'b0; stall_i = 1'b0;
    step(); check_valid("redirT", 16, 64'h40);

    // Flush: one bubble, skipped word not re-fetched
    flush_i = 1'b1;
    step(); check_bubble("flush"); check("flush.addr", bus.imem_addr_o, 64'h48);
    flush_i = 1'b0;
    step(); check_valid("postflush", 18, 64'h48);

    // PC wrap at the top of the address space
    redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); check_bubble("wrapR"); check("wrapR.addr", bus.imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    redirect_i = 1'b0;
    step();
    check_valid("wrap", 255, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap.addr", bus.imem_addr_o, 64'h0);

    // Halt: absorbing, PC frozen
    halt_i = 1'b1;
    step();
    check("halt.halted", 64'(halted_o), 64'd1);
    check_bubble("halt");
    check("halt.addr", bus.imem_addr_o, 64'h0);
    halt_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halted.valid", 64'(bus.ifid_valid_o), 64'd0);
      check("halted.addr", bus.imem_addr_o, 64'h0);
      check("halted.flag", 64'(halted_o), 64'd1);
    end

    // Reset pulse restarts from BOOT
    #2 rst_n = 1'b0;
    #2;
    check("rst2.halted", 64'(halted_o), 64'd0);
    check("rst2.addr", bus.imem_addr_o, 64'h0);
    rst_n = 1'b1;
    step(); check_bubble("boot2");
    step(); check_valid("fetchA2", 0, 64'h0);

    // Misaligned redirect
    redirect_i = 1'b1; redirect_pc_i = 64'h42;
    step();
    redirect_i = 1'b0;
    check_bubble("misR");
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis.flag",   64'(misaligned_o), 64'd1);
    check("mis.halted", 64'(halted_o), 64'd1);
    check("mis.addr",   bus.imem_addr_o, 64'h4);
    step();
    check("mis.sticky", 64'(misaligned_o), 64'd1);
    check("mis.addr2",  bus.imem_addr_o, 64'h4);
`else
    check("mis.flag",   64'(misaligned_o), 64'd0);
    check("mis.halted", 64'(halted_o), 64'd0);
    check("mis.addr",   bus.imem_addr_o, 64'h40);
    step();
    check_valid("misT", 16, 64'h40);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction with its PC into the IF/ID pipeline register for decode. Handles stall, flush, redirect from EX, and halt. It sits directly upstream of decode and is the only master of the instruction memory.

## Interface
Parameters:
- RESET_PC, default 64'h0: PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold the PC and the IF/ID register (load-use hazard from ID).
- flush_i  in  1  load a bubble into IF/ID.
- redirect_i  in  1  taken branch or jump resolved in EX.
- redirect_pc_i  in  `DataBusBits  redirect target.
- halt_i  in  1  stop fetching (ebreak/ecall retired).
- imem_addr_o  out  `DataBusBits  byte address to the instruction memory (= PC).
- imem_instr_i  in  `InstrBusBits  combinational instruction read for imem_addr_o.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_pc_o  out  `DataBusBits  PC of the IF/ID instruction.
- ifid_pc4_o  out  `DataBusBits  ifid_pc_o + 4 (link value).
- ifid_instr_o  out  `InstrBusBits  instruction, or NOP 32'h00000013 when not valid.
- halted_o  out  1  fetch is in HALTED.
- misaligned_o  out  1  sticky misaligned-redirect flag (FETCH_MISALIGN_TRAP_EN only; tied 0 otherwise).

## Operation
- States: BOOT, RUN, HALTED.
- Reset (asynchronous, rst_n=0): PC=RESET_PC, state=BOOT, ifid_valid_o=0, ifid_instr_o=NOP, ifid_pc_o=0, ifid_pc4_o=0, halted_o=0, misaligned_o=0.
- BOOT: lasts exactly one cycle after reset release; PC held, IF/ID stays bubble; next state RUN unconditionally.
- RUN, per edge, priority highest first:
  1. halt_i: state→HALTED, IF/ID←bubble, PC held.
  2. redirect_i: PC←redirect_pc_i, IF/ID←bubble (stall_i and flush_i ignored).
  3. stall_i: PC and IF/ID unchanged.
  4. flush_i: PC←PC+4, IF/ID←bubble.
  5. otherwise: IF/ID←{valid=1, PC, PC+4, imem_instr_i}; PC←PC+4.
- HALTED: absorbing until reset; PC frozen; IF/ID bubble; halted_o=1.
- imem_addr_o = PC continuously in all states.
- Arithmetic: PC+4 is modulo 2^`DataBusBits; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
- The instruction memory decodes only 256 words, so addresses ≥ 0x400 alias; this block does not check range.

## Timing
- Instruction at PC appears on ifid_* one edge after PC is presented (1-cycle fetch latency).
- The first valid IF/ID instruction appears on the second rising edge after rst_n deasserts (BOOT, then RUN capture).
- Redirect penalty: the edge that samples redirect_i yields one bubble; the target instruction is valid in IF/ID on the following edge.
- All outputs are registered except imem_addr_o, which is driven directly from the PC register.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc_i[1:0]≠0 sets misaligned_o (sticky until reset), moves state to HALTED, leaves PC unchanged, and loads a bubble.
- Undefined: redirect_pc_i[1:0] are forced to 0 on load; misaligned_o is constant 0.

## Structure
- Add to diagv2_const.vh: NOP encoding (32'h00000013), fetch state encodings (2 bits), and the default reset PC.
- One sub-module, fetch_pc_gen: PC register plus next-PC priority mux (halt/redirect/stall/+4). The IF/ID register and FSM stay in fetch_stage.

## Test plan
- Reset, RESET_PC=0, imem words 0..3 = A,B,C,D → ifid_valid_o=0 for BOOT; then ifid_instr_o=A, pc=0, pc4=4; then B at pc=4.
- stall_i high 2 cycles while IF/ID holds B at pc=4 → B/pc=4 held 2 cycles; C at pc=8 follows.
- redirect_i with redirect_pc_i=0x40 while stall_i=1 → one bubble (valid=0, instr=NOP); next edge instr=imem[16], pc=0x40.
- flush_i single cycle in RUN → one bubble; the skipped-over instruction is not re-fetched; PC advances by 4.
- halt_i in RUN → halted_o=1 next edge; PC frozen; valid stays 0 for 10 cycles; rst_n pulse → BOOT, PC=RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x42 → misaligned_o=1, halted_o=1, PC unchanged. Without the macro → PC=0x40.
